ahb_lite_arb_2m: RTL and testbench



---
 rtl/ahb_lite_arb_2m.sv | 180 ++++++++++++++++++
 tb/tb_ahb_lite_arb_2m.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_arb_2m.sv
// rtl/ahb_lite_arb_2m.sv - two-master AHB-Lite arbiter and slave-bus multiplexer
// Optional ARB_LOCK_EN: adds M0/M1_HMASTLOCK inputs and HMASTLOCK output for locked sequences.
module ahb_lite_arb_2m #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int RR = 1
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic [AW-1:0] M0_HADDR,
  input  logic [1:0]    M0_HTRANS,
  input  logic          M0_HWRITE,
  input  logic [2:0]    M0_HSIZE,
  input  logic [DW-1:0] M0_HWDATA,
  output logic          M0_HREADY,
  input  logic [AW-1:0] M1_HADDR,
  input  logic [1:0]    M1_HTRANS,
  input  logic          M1_HWRITE,
  input  logic [2:0]    M1_HSIZE,
  input  logic [DW-1:0] M1_HWDATA,
  output logic          M1_HREADY,
  output logic [DW-1:0] M_HRDATA,
`ifdef ARB_LOCK_EN
  input  logic          M0_HMASTLOCK,
  input  logic          M1_HMASTLOCK,
  output logic          HMASTLOCK,
`endif
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [DW-1:0] HWDATA,
  output logic          HMASTER,
  input  logic          HREADY,
  input  logic [DW-1:0] HRDATA
);

  logic          pend0, pend1;
  logic [AW-1:0] hold_addr0, hold_addr1;
  logic          hold_write0, hold_write1;
  logic [2:0]    hold_size0, hold_size1;
  logic          dph_valid, dph_id;
  logic          last_grant;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic          master_q;

  logic          live0, live1, req0, req1;
  logic          win_valid, win_id, slot_go;
  logic [AW-1:0] f0_addr, f1_addr;
  logic          f0_write, f1_write;
  logic [2:0]    f0_size, f1_size;

  // Only the NONSEQ/SEQ bit matters; BUSY and IDLE look the same to the arbiter.
  logic unused_htrans;
  assign unused_htrans = M0_HTRANS[0] ^ M1_HTRANS[0];

`ifdef ARB_LOCK_EN
  logic hold_lock0, hold_lock1;
  logic locked, lock_id;
  logic f0_lock, f1_lock, win_lock;
  assign f0_lock  = pend0 ? hold_lock0 : M0_HMASTLOCK;
  assign f1_lock  = pend1 ? hold_lock1 : M1_HMASTLOCK;
  assign win_lock = win_id ? f1_lock : f0_lock;
`endif

  // Data-phase ownership wins; otherwise a pending master is held off.
  assign M0_HREADY = (dph_valid && !dph_id) ? HREADY : !pend0;
  assign M1_HREADY = (dph_valid &&  dph_id) ? HREADY : !pend1;

  assign live0 = M0_HREADY & M0_HTRANS[1];
  assign live1 = M1_HREADY & M1_HTRANS[1];
  assign req0  = pend0 | live0;
  assign req1  = pend1 | live1;

  assign f0_addr  = pend0 ? hold_addr0  : M0_HADDR;
  assign f0_write = pend0 ? hold_write0 : M0_HWRITE;
  assign f0_size  = pend0 ? hold_size0  : M0_HSIZE;
  assign f1_addr  = pend1 ? hold_addr1  : M1_HADDR;
  assign f1_write = pend1 ? hold_write1 : M1_HWRITE;
  assign f1_size  = pend1 ? hold_size1  : M1_HSIZE;

  always_comb begin
    win_valid = req0 | req1;
    if (req0 && req1) begin
      win_id = (RR != 0) ? ~last_grant : 1'b1;
    end else begin
      win_id = req1;
    end
`ifdef ARB_LOCK_EN
    if (locked && (lock_id ? (req1 && f1_lock) : (req0 && f0_lock))) begin
      win_id = lock_id;
    end
`endif
  end

  assign slot_go = HREADY & win_valid;

  assign HTRANS  = slot_go ? 2'b10 : 2'b00;
  assign HADDR   = slot_go ? (win_id ? f1_addr  : f0_addr)  : addr_q;
  assign HWRITE  = slot_go ? (win_id ? f1_write : f0_write) : write_q;
  assign HSIZE   = slot_go ? (win_id ? f1_size  : f0_size)  : size_q;
  assign HMASTER = slot_go ? win_id : master_q;
`ifdef ARB_LOCK_EN
  assign HMASTLOCK = slot_go ? win_lock : 1'b0;
`endif

  assign HWDATA   = dph_valid ? (dph_id ? M1_HWDATA : M0_HWDATA) : '0;
  assign M_HRDATA = HRDATA;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend0       <= 1'b0;
      pend1       <= 1'b0;
      hold_addr0  <= '0;
      hold_addr1  <= '0;
      hold_write0 <= 1'b0;
      hold_write1 <= 1'b0;
      hold_size0  <= '0;
      hold_size1  <= '0;
      dph_valid   <= 1'b0;
      dph_id      <= 1'b0;
      last_grant  <= 1'b1;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      master_q    <= 1'b0;
`ifdef ARB_LOCK_EN
      hold_lock0  <= 1'b0;
      hold_lock1  <= 1'b0;
      locked      <= 1'b0;
      lock_id     <= 1'b0;
`endif
    end else begin
      // A live request that does not win this edge is absorbed and replayed later.
      if (live0 && !(slot_go && !win_id)) begin
        pend0       <= 1'b1;
        hold_addr0  <= M0_HADDR;
        hold_write0 <= M0_HWRITE;
        hold_size0  <= M0_HSIZE;
`ifdef ARB_LOCK_EN
        hold_lock0  <= M0_HMASTLOCK;
`endif
      end
      if (live1 && !(slot_go && win_id)) begin
        pend1       <= 1'b1;
        hold_addr1  <= M1_HADDR;
        hold_write1 <= M1_HWRITE;
        hold_size1  <= M1_HSIZE;
`ifdef ARB_LOCK_EN
        hold_lock1  <= M1_HMASTLOCK;
`endif
      end
      if (HREADY) begin
        if (win_valid) begin
          if (win_id) begin
            pend1 <= 1'b0;
          end else begin
            pend0 <= 1'b0;
          end
          dph_valid  <= 1'b1;
          dph_id     <= win_id;
          last_grant <= win_id;
          addr_q     <= HADDR;
          write_q    <= HWRITE;
          size_q     <= HSIZE;
          master_q   <= win_id;
        end else begin
          dph_valid <= 1'b0;
        end
`ifdef ARB_LOCK_EN
        locked  <= slot_go & win_lock;
        lock_id <= win_id;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_arb_2m.sv
// tb/tb_ahb_lite_arb_2m.sv - scoreboard bench for ahb_lite_arb_2m, round-robin and fixed-priority builds
module tb_ahb_lite_arb_2m;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    size;
    logic [DW-1:0] wdata;
  } xfer_t;

  typedef struct {
    logic  go;
    xfer_t x;
  } stim_t;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  logic [1:0]    htrans_m [2];
  logic [AW-1:0] haddr_m  [2];
  logic          hwrite_m [2];
  logic [2:0]    hsize_m  [2];
  logic [DW-1:0] hwdata_m [2];
  logic          s_hready;
  logic [DW-1:0] s_hrdata;

  logic          rr_m0_hready, rr_m1_hready, fp_m0_hready, fp_m1_hready;
  logic [DW-1:0] rr_m_hrdata, fp_m_hrdata, rr_hwdata, fp_hwdata;
  logic [AW-1:0] rr_haddr, fp_haddr;
  logic [1:0]    rr_htrans, fp_htrans;
  logic          rr_hwrite, fp_hwrite, rr_hmaster, fp_hmaster;
  logic [2:0]    rr_hsize, fp_hsize;
`ifdef ARB_LOCK_EN
  logic          rr_hmastlock, fp_hmastlock;
`endif

  ahb_lite_arb_2m #(.AW(AW), .DW(DW), .RR(1)) dut_rr (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HADDR(haddr_m[0]), .M0_HTRANS(htrans_m[0]), .M0_HWRITE(hwrite_m[0]),
    .M0_HSIZE(hsize_m[0]), .M0_HWDATA(hwdata_m[0]), .M0_HREADY(rr_m0_hready),
    .M1_HADDR(haddr_m[1]), .M1_HTRANS(htrans_m[1]), .M1_HWRITE(hwrite_m[1]),
    .M1_HSIZE(hsize_m[1]), .M1_HWDATA(hwdata_m[1]), .M1_HREADY(rr_m1_hready),
    .M_HRDATA(rr_m_hrdata),
`ifdef ARB_LOCK_EN
    .M0_HMASTLOCK(1'b0), .M1_HMASTLOCK(1'b0), .HMASTLOCK(rr_hmastlock),
`endif
    .HADDR(rr_haddr), .HTRANS(rr_htrans), .HWRITE(rr_hwrite), .HSIZE(rr_hsize),
    .HWDATA(rr_hwdata), .HMASTER(rr_hmaster), .HREADY(s_hready), .HRDATA(s_hrdata)
  );

  ahb_lite_arb_2m #(.AW(AW), .DW(DW), .RR(0)) dut_fp (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HADDR(haddr_m[0]), .M0_HTRANS(htrans_m[0]), .M0_HWRITE(hwrite_m[0]),
    .M0_HSIZE(hsize_m[0]), .M0_HWDATA(hwdata_m[0]), .M0_HREADY(fp_m0_hready),
    .M1_HADDR(haddr_m[1]), .M1_HTRANS(htrans_m[1]), .M1_HWRITE(hwrite_m[1]),
    .M1_HSIZE(hsize_m[1]), .M1_HWDATA(hwdata_m[1]), .M1_HREADY(fp_m1_hready),
    .M_HRDATA(fp_m_hrdata),
`ifdef ARB_LOCK_EN
    .M0_HMASTLOCK(1'b0), .M1_HMASTLOCK(1'b0), .HMASTLOCK(fp_hmastlock),
`endif
    .HADDR(fp_haddr), .HTRANS(fp_htrans), .HWRITE(fp_hwrite), .HSIZE(fp_hsize),
    .HWDATA(fp_hwdata), .HMASTER(fp_hmaster), .HREADY(s_hready), .HRDATA(s_hrdata)
  );

  // sel=0 observes the round-robin instance, sel=1 the fixed-priority one.
  logic sel = 1'b0;
  logic          t_m0_hready, t_m1_hready, t_hwrite, t_hmaster;
  logic [DW-1:0] t_m_hrdata, t_hwdata;
  logic [AW-1:0] t_haddr;
  logic [1:0]    t_htrans;
  logic [2:0]    t_hsize;
  assign t_m0_hready = sel ? fp_m0_hready : rr_m0_hready;
  assign t_m1_hready = sel ? fp_m1_hready : rr_m1_hready;
  assign t_m_hrdata  = sel ? fp_m_hrdata  : rr_m_hrdata;
  assign t_haddr     = sel ? fp_haddr     : rr_haddr;
  assign t_htrans    = sel ? fp_htrans    : rr_htrans;
  assign t_hwrite    = sel ? fp_hwrite    : rr_hwrite;
  assign t_hsize     = sel ? fp_hsize     : rr_hsize;
  assign t_hwdata    = sel ? fp_hwdata    : rr_hwdata;
  assign t_hmaster   = sel ? fp_hmaster   : rr_hmaster;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rdfun(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  stim_t stim0[$], stim1[$];
  xfer_t exp0[$], exp1[$];
  logic  hr_plan[$];
  logic  rand_mode = 1'b0;
  logic  mon_en = 1'b0;

  logic  dp_v  [2];
  xfer_t dp_x  [2];
  xfer_t cur_x [2];
  logic  sdp_v;
  logic [AW-1:0] sdp_a;

  task automatic send(input int m, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    stim_t s;
    s.go = 1'b1;
    s.x.addr = a;
    s.x.write = w;
    s.x.size = 3'd2;
    s.x.wdata = d;
    if (m == 0) stim0.push_back(s);
    else stim1.push_back(s);
  endtask

  // Master behaviour at an edge where its own HREADY was high.
  task automatic advance(input int m);
    stim_t s;
    logic have;
    dp_v[m] = htrans_m[m][1];
    if (htrans_m[m][1]) begin
      dp_x[m] = cur_x[m];
      hwdata_m[m] = cur_x[m].wdata;
    end
    have = 1'b0;
    if (m == 0 && stim0.size() > 0) begin s = stim0.pop_front(); have = 1'b1; end
    if (m == 1 && stim1.size() > 0) begin s = stim1.pop_front(); have = 1'b1; end
    if (have && s.go) begin
      htrans_m[m] = (rand_mode && $urandom_range(1) == 1) ? 2'b11 : 2'b10;
      haddr_m[m]  = s.x.addr;
      hwrite_m[m] = s.x.write;
      hsize_m[m]  = s.x.size;
      cur_x[m]    = s.x;
      if (m == 0) exp0.push_back(s.x);
      else exp1.push_back(s.x);
    end else begin
      htrans_m[m] = (rand_mode && $urandom_range(1) == 1) ? 2'b01 : 2'b00;
      if (rand_mode) haddr_m[m] = $urandom;
    end
  endtask

  task automatic refill(input int m);
    stim_t s;
    s.go = ($urandom_range(9) < 6);
    s.x.addr = $urandom;
    s.x.write = $urandom_range(1) == 1;
    s.x.size = 3'($urandom_range(2));
    s.x.wdata = $urandom;
    if (m == 0 && stim0.size() == 0) stim0.push_back(s);
    if (m == 1 && stim1.size() == 0) stim1.push_back(s);
  endtask

  task automatic step();
    logic r0, r1, sh, take;
    logic [DW-1:0] rd;
    logic [AW-1:0] a;
    @(negedge HCLK);
    r0 = t_m0_hready;
    r1 = t_m1_hready;
    rd = t_m_hrdata;
    sh = s_hready;
    take = sh && t_htrans[1];
    a = t_haddr;
    if (r0 && dp_v[0] && !dp_x[0].write) check("m0_rdata", 64'(rd), 64'(rdfun(dp_x[0].addr)));
    if (r1 && dp_v[1] && !dp_x[1].write) check("m1_rdata", 64'(rd), 64'(rdfun(dp_x[1].addr)));
    @(posedge HCLK);
    #1;
    if (r0) advance(0);
    if (r1) advance(1);
    if (sh) begin
      sdp_v = take;
      if (take) sdp_a = a;
    end
    s_hrdata = sdp_v ? rdfun(sdp_a) : DW'($urandom);
    if (hr_plan.size() > 0) s_hready = hr_plan.pop_front();
    else if (rand_mode) s_hready = ($urandom_range(3) != 0);
    else s_hready = 1'b1;
    if (rand_mode) begin
      refill(0);
      refill(1);
    end
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    HRESET = 1'b1;
    stim0.delete();
    stim1.delete();
    exp0.delete();
    exp1.delete();
    hr_plan.delete();
    for (int m = 0; m < 2; m++) begin
      htrans_m[m] = 2'b00;
      haddr_m[m]  = '0;
      hwrite_m[m] = 1'b0;
      hsize_m[m]  = '0;
      hwdata_m[m] = '0;
      dp_v[m]     = 1'b0;
    end
    s_hready = 1'b1;
    s_hrdata = '0;
    sdp_v = 1'b0;
    sdp_a = '0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    mon_en = 1'b1;
    #1;
    check("rst_htrans", 64'(t_htrans), 64'd0);
    check("rst_m0_hready", 64'(t_m0_hready), 64'd1);
    check("rst_m1_hready", 64'(t_m1_hready), 64'd1);
    check("rst_hwdata", 64'(t_hwdata), 64'd0);
    check("rst_haddr", 64'(t_haddr), 64'd0);
    check("rst_hmaster", 64'(t_hmaster), 64'd0);
  endtask

  // Monitor: every slave-bus slot is matched against the issuing master's queue.
  logic  msdp_v;
  xfer_t msdp_x;
  xfer_t mon_e;
  logic  last_m;
  int    mon_m;
  always @(negedge HCLK) begin
    if (!mon_en) begin
      msdp_v = 1'b0;
      last_m = 1'b1;
    end else if (!s_hready) begin
      check("no_slot_idle", 64'(t_htrans), 64'd0);
    end else begin
      if (msdp_v && msdp_x.write) check("hwdata", 64'(t_hwdata), 64'(msdp_x.wdata));
      else if (!msdp_v) check("hwdata_none", 64'(t_hwdata), 64'd0);
      msdp_v = 1'b0;
      if (t_htrans == 2'b10) begin
        mon_m = int'(t_hmaster);
        if (exp0.size() > 0 && exp1.size() > 0) begin
          if (sel) check("tie_fixed", 64'(t_hmaster), 64'd1);
          else check("tie_rr", 64'(t_hmaster), 64'(!last_m));
        end
        check("slot_has_req", 64'(mon_m == 0 ? exp0.size() : exp1.size()) != 0, 64'd1);
        if ((mon_m == 0 && exp0.size() > 0) || (mon_m == 1 && exp1.size() > 0)) begin
          mon_e = (mon_m == 0) ? exp0.pop_front() : exp1.pop_front();
          check("addr_ctl", {t_haddr, 28'd0, t_hwrite, t_hsize},
                {mon_e.addr, 28'd0, mon_e.write, mon_e.size});
          msdp_v = 1'b1;
          msdp_x = mon_e;
        end
        last_m = t_hmaster;
      end else begin
        check("idle_code", 64'(t_htrans), 64'd0);
        check("work_conserving", 64'({exp0.size() != 0, exp1.size() != 0}), 64'd0);
      end
    end
  end

  initial begin
    // Round-robin instance.
    sel = 1'b0;
    do_reset();

    send(0, 32'h0000_1000, 1'b1, 32'hDEAD_BEEF);
    step();
    check("a_htrans", 64'(t_htrans), 64'h2);
    check("a_haddr", 64'(t_haddr), 64'h1000);
    check("a_hmaster", 64'(t_hmaster), 64'd0);
    check("a_m1_hready", 64'(t_m1_hready), 64'd1);
    step();
    check("a_hwdata", 64'(t_hwdata), 64'hDEAD_BEEF);
    check("a_m1_hready2", 64'(t_m1_hready), 64'd1);
    check("a_idle", 64'(t_htrans), 64'd0);

    do_reset();
    send(0, 32'h0000_2000, 1'b0, 32'h0);
    send(1, 32'h0000_3000, 1'b1, 32'h1111_1111);
    step();
    check("b_hmaster0", 64'(t_hmaster), 64'd0);
    check("b_haddr0", 64'(t_haddr), 64'h2000);
    step();
    check("b_m1_stall", 64'(t_m1_hready), 64'd0);
    check("b_hmaster1", 64'(t_hmaster), 64'd1);
    check("b_haddr1", 64'(t_haddr), 64'h3000);
    check("b_htrans1", 64'(t_htrans), 64'h2);
    step();
    check("b_m1_done", 64'(t_m1_hready), 64'd1);
    check("b_hwdata", 64'(t_hwdata), 64'h1111_1111);

    send(0, 32'h0000_4000, 1'b1, 32'hCAFE_0001);
    step();
    check("c_hmaster0", 64'(t_hmaster), 64'd0);
    send(1, 32'h0000_5000, 1'b1, 32'hCAFE_0002);
    repeat (3) hr_plan.push_back(1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("c_wait_idle", 64'(t_htrans), 64'd0);
      check("c_m0_mirror", 64'(t_m0_hready), 64'd0);
      check("c_m1_ready", 64'(t_m1_hready), 64'(k == 0));
    end
    step();
    check("c_grant_htrans", 64'(t_htrans), 64'h2);
    check("c_grant_m1", 64'(t_hmaster), 64'd1);
    check("c_grant_addr", 64'(t_haddr), 64'h5000);
    check("c_m0_done", 64'(t_m0_hready), 64'd1);
    check("c_m0_wdata", 64'(t_hwdata), 64'hCAFE_0001);
    step();
    check("c_m1_wdata", 64'(t_hwdata), 64'hCAFE_0002);

    rand_mode = 1'b1;
    repeat (1500) step();
    rand_mode = 1'b0;
    repeat (12) step();
    check("rr_drain", 64'(exp0.size() + exp1.size()), 64'd0);

    // Fixed-priority instance.
    sel = 1'b1;
    do_reset();
    for (int k = 0; k < 6; k++) send(0, 32'h0000_6000 + 32'(k * 4), 1'b1, 32'hA000_0000 + 32'(k));
    for (int k = 0; k < 4; k++) send(1, 32'h0000_7000 + 32'(k * 4), 1'b1, 32'hB000_0000 + 32'(k));
    for (int k = 0; k < 4; k++) begin
      step();
      check("d_m1_wins", 64'(t_hmaster), 64'd1);
      check("d_htrans", 64'(t_htrans), 64'h2);
      if (k > 0) check("d_m0_stall", 64'(t_m0_hready), 64'd0);
    end
    step();
    check("d_m0_after_idle", 64'(t_hmaster), 64'd0);
    check("d_m0_addr", 64'(t_haddr), 64'h6000);
    repeat (10) step();

    rand_mode = 1'b1;
    repeat (1500) step();
    rand_mode = 1'b0;
    repeat (16) step();
    check("fp_drain", 64'(exp0.size() + exp1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
